// File: rtl/dac_spi_driver_pkg.sv
// dac_spi_driver_pkg: DAC constants and types shared by the DAC driver and the upstream buffer stage.
//   dac_channels     - number of DAC lanes (one SDI line each)
//   dac_word_w       - bits per sample word
//   dac_wait_timeout - cycles the driver waits for an upstream response
//   dac_state_t      - driver FSM states
//   lane_word()      - extracts a channel word (channel 0 is the top word)
package dac_spi_driver_pkg;

    localparam int dac_channels     = 4;
    localparam int dac_word_w       = 32;
    localparam int dac_wait_timeout = 4;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, SHIFT, LATCH} dac_state_t;

    function automatic logic [dac_word_w-1:0] lane_word(
        input logic [dac_channels*dac_word_w-1:0] words,
        input int                                 ch
    );
        return words[(dac_channels-1-ch)*dac_word_w +: dac_word_w];
    endfunction

endpackage

// File: rtl/dac_spi_driver_if.sv
// dac_spi_driver_if: upstream sample handshake plus the SPI/LDAC pins of the DAC driver.
//   dac_open, dac_buffer, dac_buffer_ready, dac_underrun, dac_request - upstream FIFO handshake
//   dac_sck, dac_cs_n, dac_sdi, dac_ldac_n                           - DAC serial pins
//   master: the driver; slave: the upstream/DAC side
interface dac_spi_driver_if;

    import dac_spi_driver_pkg::*;

    logic                                 dac_open;
    logic [dac_channels*dac_word_w-1:0]   dac_buffer;
    logic                                 dac_buffer_ready;
    logic                                 dac_underrun;
    logic                                 dac_request;
    logic                                 dac_sck;
    logic                                 dac_cs_n;
    logic [dac_channels-1:0]              dac_sdi;
    logic                                 dac_ldac_n;

    modport master (
        input  dac_open, dac_buffer, dac_buffer_ready, dac_underrun,
        output dac_request, dac_sck, dac_cs_n, dac_sdi, dac_ldac_n
    );

    modport slave (
        output dac_open, dac_buffer, dac_buffer_ready, dac_underrun,
        input  dac_request, dac_sck, dac_cs_n, dac_sdi, dac_ldac_n
    );

endinterface

// File: rtl/dac_sample_timer.sv
// dac_sample_timer: free-running sample-rate divider, one tick every SAMPLE_DIV cycles.
//   capture_clk, reset - clock and async active-high reset
//   enable             - count while high
//   clear              - hold the count at zero
//   tick               - one-cycle pulse on the last cycle of each period
module dac_sample_timer #(
    parameter int SAMPLE_DIV = 512
) (
    input  logic capture_clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    logic [15:0] cnt;

    assign tick = enable && cnt == 16'(SAMPLE_DIV - 1);

    always_ff @(posedge capture_clk or posedge reset)
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + 16'd1;

endmodule

// File: rtl/dac_spi_driver.sv
// dac_spi_driver: requests one sample per period and shifts it to a multi-lane SPI DAC, then pulses LDAC.
//   capture_clk, reset - sole clock and async active-high reset (released synchronously inside)
//   dac (master)       - upstream handshake and DAC pins, see dac_spi_driver_if
//   underrun_count     - saturating count of frames that repeated the held words
//   sample_count       - LDAC pulses since open (only when DAC_SAMPLE_COUNT_EN is defined)
module dac_spi_driver
    import dac_spi_driver_pkg::*;
#(
    parameter int SAMPLE_DIV = 512
) (
    input  logic               capture_clk,
    input  logic               reset,
    dac_spi_driver_if.master   dac,
    output logic [15:0]        underrun_count
`ifdef DAC_SAMPLE_COUNT_EN
  , output logic [31:0]        sample_count
`endif
);

    // ph indexes the current cycle within WAIT, SHIFT and LATCH
    localparam logic [6:0] wait_last  = 7'(dac_wait_timeout - 1);
    localparam logic [6:0] edge_last  = 7'(2 * dac_word_w);
    localparam logic [6:0] frame_last = edge_last + 7'd1;

    logic [1:0]            rst_sync;
    logic                  rst_i;
    logic                  tick;
    dac_state_t            state;
    logic [6:0]            ph;
    logic [15:0]           underrun_q;
    logic [dac_word_w-1:0] sr   [dac_channels];
    logic [dac_word_w-1:0] held [dac_channels];
    logic [dac_word_w-1:0] load [dac_channels];

    // assert immediately, release two clean edges later
    always_ff @(posedge capture_clk or posedge reset)
        if (reset)
            rst_sync <= 2'b11;
        else
            rst_sync <= {rst_sync[0], 1'b0};

    assign rst_i          = rst_sync[1];
    assign underrun_count = underrun_q;

    dac_sample_timer #(.SAMPLE_DIV(SAMPLE_DIV)) u_timer (
        .capture_clk (capture_clk),
        .reset       (rst_i),
        .enable      (dac.dac_open),
        .clear       (!dac.dac_open),
        .tick        (tick)
    );

    // words for the coming frame: fresh buffer, or the previous frame repeated
    for (genvar g = 0; g < dac_channels; g++) begin : g_load
        assign load[g] = dac.dac_buffer_ready ? lane_word(dac.dac_buffer, g) : held[g];
    end

    always_ff @(posedge capture_clk or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            ph              <= '0;
            underrun_q      <= '0;
            sr              <= '{default: '0};
            held            <= '{default: '0};
            dac.dac_request <= 1'b0;
            dac.dac_sck     <= 1'b0;
            dac.dac_cs_n    <= 1'b1;
            dac.dac_sdi     <= '0;
            dac.dac_ldac_n  <= 1'b1;
        end else if (!dac.dac_open) begin
            // closing aborts any frame; held words restart from zero on the next open
            state           <= IDLE;
            ph              <= '0;
            held            <= '{default: '0};
            dac.dac_request <= 1'b0;
            dac.dac_sck     <= 1'b0;
            dac.dac_cs_n    <= 1'b1;
            dac.dac_sdi     <= '0;
            dac.dac_ldac_n  <= 1'b1;
        end else begin
            dac.dac_request <= 1'b0;
            case (state)
                IDLE: if (tick) begin
                    state           <= REQ;
                    dac.dac_request <= 1'b1;
                end
                REQ: begin
                    state <= WAIT;
                    ph    <= '0;
                end
                WAIT: begin
                    ph <= ph + 7'd1;
                    if (dac.dac_buffer_ready || dac.dac_underrun || ph == wait_last) begin
                        state        <= SHIFT;
                        ph           <= '0;
                        dac.dac_cs_n <= 1'b0;
                        dac.dac_sck  <= 1'b0;
                        if (!dac.dac_buffer_ready && underrun_q != 16'hFFFF)
                            underrun_q <= underrun_q + 16'd1;
                        for (int c = 0; c < dac_channels; c++) begin
                            sr[c]                        <= load[c];
                            held[c]                      <= load[c];
                            dac.dac_sdi[dac_channels-1-c] <= load[c][dac_word_w-1];
                        end
                    end
                end
                SHIFT: begin
                    ph <= ph + 7'd1;
                    if (ph < edge_last)
                        dac.dac_sck <= ~dac.dac_sck;
                    // sck is high on odd ph; move data on the following low phase
                    if (ph[0] && ph < edge_last - 7'd1)
                        for (int c = 0; c < dac_channels; c++) begin
                            sr[c]                        <= {sr[c][dac_word_w-2:0], 1'b0};
                            dac.dac_sdi[dac_channels-1-c] <= sr[c][dac_word_w-2];
                        end
                    if (ph == edge_last) begin
                        dac.dac_cs_n <= 1'b1;
                        dac.dac_sdi  <= '0;
                    end
                    if (ph == frame_last) begin
                        state          <= LATCH;
                        ph             <= '0;
                        dac.dac_ldac_n <= 1'b0;
                    end
                end
                LATCH: begin
                    ph <= ph + 7'd1;
                    if (ph == 7'd1) begin
                        state          <= IDLE;
                        dac.dac_ldac_n <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DAC_SAMPLE_COUNT_EN
    // counts on the edge that starts each LDAC pulse
    always_ff @(posedge capture_clk or posedge rst_i)
        if (rst_i)
            sample_count <= '0;
        else if (!dac.dac_open)
            sample_count <= '0;
        else if (state == SHIFT && ph == frame_last)
            sample_count <= sample_count + 32'd1;
`endif

endmodule

// File: tb/tb_dac_spi_driver.sv
// tb_dac_spi_driver: directed self-checking bench for dac_spi_driver (SAMPLE_DIV = 96).
module tb_dac_spi_driver;

    localparam int DIV = 96;
    localparam logic [127:0] WA = {32'hA5A50001, 32'hA5A50002, 32'hA5A50003, 32'hA5A50004};
    localparam logic [127:0] WB = {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'h80000001};
    localparam logic [127:0] WC = {32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 32'h13579BDF};
    localparam logic [127:0] WD = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    // kind: 0 ready, 1 underrun, 2 silent, 3 both strobes together
    typedef struct {
        int           kind;
        int           dly;
        logic [127:0] words;
        logic [127:0] exp_words;
        int           exp_uc;
    } vec_t;

    logic        capture_clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] underrun_count;
`ifdef DAC_SAMPLE_COUNT_EN
    logic [31:0] sample_count;
`endif

    dac_spi_driver_if dac ();

    dac_spi_driver #(.SAMPLE_DIV(DIV)) dut (
        .capture_clk    (capture_clk),
        .reset          (reset),
        .dac            (dac),
        .underrun_count (underrun_count)
`ifdef DAC_SAMPLE_COUNT_EN
      , .sample_count   (sample_count)
`endif
    );

    always #5 capture_clk = ~capture_clk;

    int errors = 0;
    int checks = 0;

    logic [127:0] f_got;
    int f_lead, f_act, f_rise, f_viol, f_ldw, f_tail, f_gap, f_reqw, f_done;

    task automatic chk_i(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!dac.dac_request && n < 2 * DIV) begin
            @(posedge capture_clk); #1;
            n++;
        end
    endtask

    // called in the cycle where dac_request is high; samples one whole frame
    task automatic run_frame(input int kind, input int dly, input logic [127:0] words);
        int   cs_at, rise_at, fall_at, csh_at, ld_at;
        logic psck;
        logic [3:0] psdi;
        f_got = '0; f_act = 0; f_rise = 0; f_viol = 0; f_ldw = 0; f_reqw = 0; f_done = 0;
        cs_at = -1; rise_at = -1; fall_at = -1; csh_at = -1; ld_at = -1;
        psck = dac.dac_sck;
        psdi = dac.dac_sdi;
        dac.dac_buffer = words;
        for (int i = 1; i < 200 && f_done == 0; i++) begin
            @(posedge capture_clk); #1;
            dac.dac_buffer_ready = (kind == 0 || kind == 3) && i == dly;
            dac.dac_underrun     = (kind == 1 || kind == 3) && i == dly;
            if (dac.dac_request) f_reqw++;
            if (!dac.dac_cs_n && cs_at < 0) cs_at = i;
            if (dac.dac_sck != psck) f_act++;
            if (dac.dac_sck && !psck) begin
                if (rise_at < 0) rise_at = i;
                f_rise++;
                for (int c = 0; c < 4; c++)
                    f_got[(3-c)*32 +: 32] = {f_got[(3-c)*32 +: 31], dac.dac_sdi[3-c]};
            end
            if (!dac.dac_sck && psck) fall_at = i;
            if (dac.dac_sck && dac.dac_sdi != psdi) f_viol++;
            if (dac.dac_cs_n && cs_at >= 0 && csh_at < 0) csh_at = i;
            if (!dac.dac_ldac_n) begin
                if (ld_at < 0) ld_at = i;
                f_ldw++;
            end else if (ld_at >= 0)
                f_done = 1;
            psck = dac.dac_sck;
            psdi = dac.dac_sdi;
        end
        dac.dac_buffer_ready = 1'b0;
        dac.dac_underrun     = 1'b0;
        f_lead = rise_at - cs_at;
        f_tail = csh_at - fall_at;
        f_gap  = ld_at - csh_at;
    endtask

    task automatic check_frame(input string tag, input logic [127:0] ew, input int euc);
        chk_i({tag, " done"},           f_done, 1);
        chk_w({tag, " words"},          f_got, ew);
        chk_i({tag, " cs_lead"},        f_lead, 1);
        chk_i({tag, " sck_edges"},      f_act, 64);
        chk_i({tag, " sck_rises"},      f_rise, 32);
        chk_i({tag, " sdi_moves_high"}, f_viol, 0);
        chk_i({tag, " cs_tail"},        f_tail, 1);
        chk_i({tag, " ldac_gap"},       f_gap, 1);
        chk_i({tag, " ldac_width"},     f_ldw, 2);
        chk_i({tag, " req_width"},      f_reqw, 0);
        chk_i({tag, " underrun_count"}, int'(underrun_count), euc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n, rises, ld, cyc;
        logic psck;
        vec_t vecs [6];
        vecs[0] = '{0, 2, WA, WA, 0};
        vecs[1] = '{1, 2, WB, WA, 1};
        vecs[2] = '{2, 0, WB, WA, 2};
        vecs[3] = '{3, 1, WB, WB, 2};
        vecs[4] = '{0, 4, WC, WC, 2};
        vecs[5] = '{0, 5, WD, WC, 3};

        dac.dac_open = 1'b0;
        dac.dac_buffer = '0;
        dac.dac_buffer_ready = 1'b0;
        dac.dac_underrun = 1'b0;

        #2 reset = 1'b1;
        #1;
        chk_i("reset request", int'(dac.dac_request), 0);
        chk_i("reset sck", int'(dac.dac_sck), 0);
        chk_i("reset cs_n", int'(dac.dac_cs_n), 1);
        chk_i("reset sdi", int'(dac.dac_sdi), 0);
        chk_i("reset ldac_n", int'(dac.dac_ldac_n), 1);
        chk_i("reset underrun_count", int'(underrun_count), 0);
`ifdef DAC_SAMPLE_COUNT_EN
        chk_i("reset sample_count", int'(sample_count), 0);
`endif
        repeat (3) @(posedge capture_clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge capture_clk);
        #1 dac.dac_open = 1'b1;

        wait_req(n);
        chk_i("open latency", n, DIV);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) wait_req(n);
            chk_i($sformatf("frame%0d request", i), int'(dac.dac_request), 1);
            run_frame(vecs[i].kind, vecs[i].dly, vecs[i].words);
            check_frame($sformatf("frame%0d", i), vecs[i].exp_words, vecs[i].exp_uc);
`ifdef DAC_SAMPLE_COUNT_EN
            chk_i($sformatf("frame%0d sample_count", i), int'(sample_count), i + 1);
`endif
        end

        wait_req(n);
        chk_i("abort request", int'(dac.dac_request), 1);
        rises = 0;
        cyc = 0;
        psck = 1'b0;
        dac.dac_buffer = WB;
        while (rises < 10 && cyc < 200) begin
            @(posedge capture_clk); #1;
            cyc++;
            dac.dac_buffer_ready = (cyc == 2);
            if (dac.dac_sck && !psck) rises++;
            psck = dac.dac_sck;
        end
        dac.dac_buffer_ready = 1'b0;
        chk_i("abort reached bit 10", rises, 10);
        dac.dac_open = 1'b0;
        @(posedge capture_clk); #1;
        chk_i("abort cs_n", int'(dac.dac_cs_n), 1);
        chk_i("abort sck", int'(dac.dac_sck), 0);
        chk_i("abort sdi", int'(dac.dac_sdi), 0);
        chk_i("abort ldac_n", int'(dac.dac_ldac_n), 1);
`ifdef DAC_SAMPLE_COUNT_EN
        chk_i("abort sample_count", int'(sample_count), 0);
`endif
        ld = 0;
        repeat (DIV) begin
            @(posedge capture_clk); #1;
            if (!dac.dac_ldac_n) ld++;
        end
        chk_i("abort no ldac", ld, 0);

        dac.dac_open = 1'b1;
        wait_req(n);
        chk_i("reopen latency", n, DIV);
        run_frame(1, 3, WC);
        check_frame("reopen underrun", '0, 4);
`ifdef DAC_SAMPLE_COUNT_EN
        chk_i("reopen sample_count", int'(sample_count), 1);
`endif

        force dut.underrun_q = 16'hFFFE;
        @(posedge capture_clk); #1;
        release dut.underrun_q;
        for (int k = 0; k < 2; k++) begin
            wait_req(n);
            chk_i($sformatf("sat%0d request", k), int'(dac.dac_request), 1);
            run_frame(2, 0, WD);
            check_frame($sformatf("sat%0d", k), '0, 65535);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
